// File: rtl/ds18b20_pkg.sv
// Shared definitions for the DS18B20 conversion scheduler: command bytes,
// PHY operation codes and the scheduler state encoding.
package ds18b20_pkg;

   localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
   localparam logic [7:0] CMD_CONVERT  = 8'h44;
   localparam logic [7:0] CMD_READ_SP  = 8'hBE;

   typedef enum logic [1:0] {
      PHY_RESET = 2'd0,
      PHY_WRITE = 2'd1,
      PHY_READ  = 2'd2
   } phy_cmd_e;

   typedef enum logic [3:0] {
      ST_IDLE, ST_RST1, ST_SKIP1, ST_CONV, ST_WAIT, ST_RST2,
      ST_SKIP2, ST_RDCMD, ST_RDL, ST_RDH, ST_DONE, ST_GAP
   } state_e;

   function automatic logic is_phy_state(state_e s);
      return s inside {ST_RST1, ST_SKIP1, ST_CONV, ST_RST2,
                       ST_SKIP2, ST_RDCMD, ST_RDL, ST_RDH};
   endfunction

   function automatic phy_cmd_e cmd_of(state_e s);
      case (s)
         ST_RST1, ST_RST2: return PHY_RESET;
         ST_RDL, ST_RDH:   return PHY_READ;
         default:          return PHY_WRITE;
      endcase
   endfunction

   function automatic logic [7:0] wdata_of(state_e s);
      case (s)
         ST_SKIP1, ST_SKIP2: return CMD_SKIP_ROM;
         ST_CONV:            return CMD_CONVERT;
         ST_RDCMD:           return CMD_READ_SP;
         default:            return 8'h00;
      endcase
   endfunction

   // Successor of each PHY state once its transaction completes normally.
   function automatic state_e phy_next(state_e s);
      case (s)
         ST_RST1:  return ST_SKIP1;
         ST_SKIP1: return ST_CONV;
         ST_CONV:  return ST_WAIT;
         ST_RST2:  return ST_SKIP2;
         ST_SKIP2: return ST_RDCMD;
         ST_RDCMD: return ST_RDL;
         ST_RDL:   return ST_RDH;
         ST_RDH:   return ST_DONE;
         default:  return ST_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/ds18b20_dly_cnt.sv
// Terminal-count delay counter: counts from 0 while enabled and flags the
// cycle it reaches term, then restarts from 0.
module ds18b20_dly_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [W-1:0] term,
   output logic         tc
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      tc    = en && (cnt_q == term);
      cnt_d = (en && !tc) ? cnt_q + W'(1) : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/ds18b20_sched.sv
// DS18B20 conversion scheduler: drives the 1-wire byte PHY through
// reset/skip/convert, waits, reads the scratchpad and publishes the raw temperature.
module ds18b20_sched
   import ds18b20_pkg::*;
#(
   parameter int unsigned TIME_750ms = 37_499_999,
   parameter int unsigned AUTO_GAP   = 4_999_999
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        auto_en,
   output logic        phy_req,
   output logic [1:0]  phy_cmd,
   output logic [7:0]  phy_wdata,
   input  logic        phy_done,
   input  logic [7:0]  phy_rdata,
   input  logic        phy_presence,
   output logic [15:0] temp_raw,
   output logic        temp_valid,
   output logic        busy,
   output logic        err_np
);

   state_e      state_q, state_d;
   logic        phy_req_q, phy_req_d;
   logic [1:0]  phy_cmd_q, phy_cmd_d;
   logic [7:0]  phy_wdata_q, phy_wdata_d;
   logic [7:0]  lsb_q, lsb_d;
   logic [15:0] temp_raw_q, temp_raw_d;
   logic        temp_valid_q, temp_valid_d;
   logic        err_np_q, err_np_d;

   logic        xfer_done;
   logic        cnt_en, cnt_tc;
   logic [31:0] cnt_term;

   assign cnt_en   = (state_q == ST_WAIT) || (state_q == ST_GAP);
   assign cnt_term = (state_q == ST_WAIT) ? 32'(TIME_750ms) : 32'(AUTO_GAP);

   ds18b20_dly_cnt #(.W(32)) u_dly_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (cnt_en),
      .term  (cnt_term),
      .tc    (cnt_tc)
   );

   // A completion only counts while our own request is outstanding.
   assign xfer_done = phy_req_q && phy_done;

   always_comb begin
      state_d      = state_q;
      phy_req_d    = 1'b0;
      phy_cmd_d    = phy_cmd_q;
      phy_wdata_d  = phy_wdata_q;
      lsb_d        = lsb_q;
      temp_raw_d   = temp_raw_q;
      temp_valid_d = 1'b0;
      err_np_d     = err_np_q;

      case (state_q)
         ST_IDLE: begin
            if (start || auto_en) begin
               state_d = ST_RST1;
               if (start) err_np_d = 1'b0;
            end
         end
         ST_WAIT: if (cnt_tc) state_d = ST_RST2;
         ST_DONE: state_d = auto_en ? ST_GAP : ST_IDLE;
         ST_GAP: begin
            if (!auto_en)    state_d = ST_IDLE;
            else if (cnt_tc) state_d = ST_RST1;
         end
         default: begin
            if (xfer_done) begin
               state_d = phy_next(state_q);
               if ((state_q == ST_RST1 || state_q == ST_RST2) && !phy_presence) begin
                  err_np_d = 1'b1;
                  state_d  = ST_IDLE;
               end
               if (state_q == ST_RDL) lsb_d = phy_rdata;
               if (state_q == ST_RDH) begin
                  temp_raw_d   = {phy_rdata, lsb_q};
                  temp_valid_d = 1'b1;
               end
            end
         end
      endcase

      // Request rises the cycle after a PHY state is entered and falls on completion.
      if (is_phy_state(state_q) && !xfer_done) begin
         phy_req_d   = 1'b1;
         phy_cmd_d   = cmd_of(state_q);
         phy_wdata_d = wdata_of(state_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         phy_req_q    <= 1'b0;
         phy_cmd_q    <= 2'd0;
         phy_wdata_q  <= 8'h00;
         lsb_q        <= 8'h00;
         temp_raw_q   <= 16'h0000;
         temp_valid_q <= 1'b0;
         err_np_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         phy_req_q    <= phy_req_d;
         phy_cmd_q    <= phy_cmd_d;
         phy_wdata_q  <= phy_wdata_d;
         lsb_q        <= lsb_d;
         temp_raw_q   <= temp_raw_d;
         temp_valid_q <= temp_valid_d;
         err_np_q     <= err_np_d;
      end
   end

   assign phy_req    = phy_req_q;
   assign phy_cmd    = phy_cmd_q;
   assign phy_wdata  = phy_wdata_q;
   assign temp_raw   = temp_raw_q;
   assign temp_valid = temp_valid_q;
   assign err_np     = err_np_q;
   assign busy       = (state_q != ST_IDLE) && (state_q != ST_GAP);

endmodule

// File: tb/tb_ds18b20_sched.sv
// Bench for ds18b20_sched: a DS18B20/PHY behavioural model scores every
// transaction and every temp_valid cycle; directed scenarios cover the main flows.
module tb_ds18b20_sched;

   localparam int T750 = 999;
   localparam int GAPN = 99;
   localparam int LAT  = 5;
   localparam logic [1:0] C_RESET = 2'd0;
   localparam logic [1:0] C_WRITE = 2'd1;
   localparam logic [1:0] C_READ  = 2'd2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        auto_en = 1'b0;
   logic        phy_req;
   logic [1:0]  phy_cmd;
   logic [7:0]  phy_wdata;
   logic        phy_done = 1'b0;
   logic [7:0]  phy_rdata = 8'h00;
   logic        phy_presence = 1'b0;
   logic [15:0] temp_raw;
   logic        temp_valid;
   logic        busy;
   logic        err_np;

   ds18b20_sched #(.TIME_750ms(T750), .AUTO_GAP(GAPN)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .auto_en      (auto_en),
      .phy_req      (phy_req),
      .phy_cmd      (phy_cmd),
      .phy_wdata    (phy_wdata),
      .phy_done     (phy_done),
      .phy_rdata    (phy_rdata),
      .phy_presence (phy_presence),
      .temp_raw     (temp_raw),
      .temp_valid   (temp_valid),
      .busy         (busy),
      .err_np       (err_np)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- behavioural sensor + PHY model ----------------
   typedef struct {
      logic [1:0] cmd;
      logic [7:0] wd;
   } txn_t;

   txn_t        exp_q[$];
   logic [15:0] sensor_word = 16'h0000;
   bit          presence_ok = 1'b1;
   bit          auto_gap_chk = 1'b0;
   bit          abort_seen = 1'b0;
   bit          rd_pending = 1'b0;
   bit          mon_en = 1'b0;
   int          rd_idx = 0;
   int          last_done_cyc = -1;
   logic [1:0]  prev_cmd = C_RESET;
   logic [7:0]  prev_wd = 8'h00;
   int          exp_valid_cyc = -1;
   logic [15:0] exp_word = 16'h0000;
   int          valid_cnt = 0;

   function automatic logic [15:0] deg_to_raw(input real d);
      int v;
      v = $rtoi(d * 16.0);
      return v[15:0];
   endfunction

   task automatic push_txn(input logic [1:0] c, input logic [7:0] w);
      txn_t t;
      t.cmd = c;
      t.wd  = w;
      exp_q.push_back(t);
   endtask

   task automatic push_conv();
      push_txn(C_RESET, 8'h00);
      push_txn(C_WRITE, 8'hCC);
      push_txn(C_WRITE, 8'h44);
      push_txn(C_RESET, 8'h00);
      push_txn(C_WRITE, 8'hCC);
      push_txn(C_WRITE, 8'hBE);
      push_txn(C_READ,  8'h00);
      push_txn(C_READ,  8'h00);
   endtask

   initial begin : phy_model
      txn_t       t;
      logic [1:0] cur_cmd;
      logic [7:0] cur_wd;
      forever begin
         @(posedge clk); #1;
         if (phy_req === 1'b1) begin
            cur_cmd = phy_cmd;
            cur_wd  = phy_wdata;
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_txn: got cmd=%0d wdata=0x%02h, required no transaction (cycle %0d)",
                        cur_cmd, cur_wd, cyc);
            end else begin
               t = exp_q.pop_front();
               chk("txn_cmd", 32'(cur_cmd), 32'(t.cmd));
               if (t.cmd == C_WRITE) chk("txn_wdata", 32'(cur_wd), 32'(t.wd));
            end
            if (cur_cmd != C_RESET && last_done_cyc >= 0)
               chk("phy_gap", cyc - last_done_cyc, 2);
            else if (cur_cmd == C_RESET && prev_cmd == C_WRITE && prev_wd == 8'h44)
               chk("wait_gap", cyc - last_done_cyc, T750 + 3);
            else if (cur_cmd == C_RESET && prev_cmd == C_READ && auto_gap_chk)
               chk("auto_gap", cyc - last_done_cyc, GAPN + 4);
            prev_cmd = cur_cmd;
            prev_wd  = cur_wd;
            if (cur_cmd == C_RESET) rd_idx = 0;
            rd_pending = (cur_cmd == C_READ) && (rd_idx == 0);
            for (int i = 0; i < LAT; i++) begin
               @(posedge clk); #1;
               if (!abort_seen) begin
                  chk("req_held", 32'(phy_req), 32'd1);
                  chk("cmd_held", 32'(phy_cmd), 32'(cur_cmd));
               end
            end
            phy_done     = 1'b1;
            phy_presence = (cur_cmd == C_RESET) ? presence_ok : 1'b0;
            phy_rdata    = (cur_cmd != C_READ) ? 8'h00 :
                           (rd_idx == 0) ? sensor_word[7:0] : sensor_word[15:8];
            last_done_cyc = cyc;
            if (cur_cmd == C_READ) begin
               if (rd_idx == 1) begin
                  exp_valid_cyc = cyc + 1;
                  exp_word      = sensor_word;
               end
               rd_idx++;
            end
            rd_pending = 1'b0;
            @(posedge clk); #1;
            phy_done     = 1'b0;
            phy_presence = 1'b0;
            phy_rdata    = 8'h00;
         end
      end
   end

   // Per-cycle compare of the result interface against the model.
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (temp_valid !== (cyc == exp_valid_cyc)) begin
            failures++;
            $display("FAIL temp_valid_timing: got %b, required %b (cycle %0d)",
                     temp_valid, (cyc == exp_valid_cyc), cyc);
         end
         if (temp_valid === 1'b1) valid_cnt++;
         if (cyc == exp_valid_cyc) chk("temp_raw_model", 32'(temp_raw), 32'(exp_word));
         if (phy_req === 1'b1) chk("busy_with_req", 32'(busy), 32'd1);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic pulse_start();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_valid(input int target, input int budget);
      int n = 0;
      while (valid_cnt < target && n < budget) begin
         @(posedge clk);
         n++;
      end
      chk("wait_valid_in_budget", 32'(valid_cnt >= target), 32'd1);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin : stim
      int n;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_phy_req", 32'(phy_req), 32'd0);
      chk("rst_phy_cmd", 32'(phy_cmd), 32'd0);
      chk("rst_phy_wdata", 32'(phy_wdata), 32'd0);
      chk("rst_temp_raw", 32'(temp_raw), 32'd0);
      chk("rst_temp_valid", 32'(temp_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_err_np", 32'(err_np), 32'd0);
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // V1: single conversion at +30.8125 C
      sensor_word = deg_to_raw(30.8125);
      chk("v1_model_word", 32'(sensor_word), 32'h01ED);
      push_conv();
      pulse_start();
      chk("v1_busy_after_start", 32'(busy), 32'd1);
      wait_valid(1, 3000);
      wait_cycles(20);
      chk("v1_temp_raw", 32'(temp_raw), 32'h01ED);
      chk("v1_valid_count", valid_cnt, 1);
      chk("v1_script_done", exp_q.size(), 0);
      chk("v1_busy_idle", 32'(busy), 32'd0);

      // V2: no presence on RST1
      presence_ok = 1'b0;
      push_txn(C_RESET, 8'h00);
      pulse_start();
      n = 0;
      while (err_np !== 1'b1 && n < 200) begin
         @(posedge clk);
         n++;
      end
      wait_cycles(20);
      chk("v2_err_np", 32'(err_np), 32'd1);
      chk("v2_busy", 32'(busy), 32'd0);
      chk("v2_valid_count", valid_cnt, 1);
      chk("v2_script_done", exp_q.size(), 0);

      // V3: start re-pulsed during WAIT is ignored
      presence_ok = 1'b1;
      push_conv();
      pulse_start();
      wait_cycles(3);
      chk("v3_err_np_cleared", 32'(err_np), 32'd0);
      wait_cycles(100);
      chk("v3_wait_busy", 32'(busy), 32'd1);
      chk("v3_wait_req_low", 32'(phy_req), 32'd0);
      pulse_start();
      wait_valid(2, 3000);
      wait_cycles(200);
      chk("v3_valid_count", valid_cnt, 2);
      chk("v3_script_done", exp_q.size(), 0);

      // V4: auto mode for three conversions, then stop during GAP
      push_conv();
      push_conv();
      push_conv();
      @(posedge clk); #1;
      auto_en = 1'b1;
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
      wait_valid(3, 3000);
      auto_gap_chk = 1'b1;
      wait_valid(5, 5000);
      wait_cycles(10);
      chk("v4_gap_not_busy", 32'(busy), 32'd0);
      auto_en = 1'b0;
      wait_cycles(200);
      auto_gap_chk = 1'b0;
      chk("v4_valid_count", valid_cnt, 5);
      chk("v4_script_done", exp_q.size(), 0);
      chk("v4_idle_busy", 32'(busy), 32'd0);

      // V5: reset while the LSB read is outstanding
      push_conv();
      pulse_start();
      n = 0;
      while (!rd_pending && n < 3000) begin
         @(posedge clk); #2;
         n++;
      end
      chk("v5_reached_rdl", 32'(rd_pending), 32'd1);
      abort_seen = 1'b1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("v5_req_dropped", 32'(phy_req), 32'd0);
      chk("v5_busy", 32'(busy), 32'd0);
      chk("v5_temp_raw", 32'(temp_raw), 32'd0);
      rst_n = 1'b1;
      exp_q.delete();
      wait_cycles(40);
      chk("v5_stale_done_req", 32'(phy_req), 32'd0);
      chk("v5_stale_done_busy", 32'(busy), 32'd0);
      chk("v5_valid_count", valid_cnt, 5);
      abort_seen = 1'b0;

      // V6: negative temperature
      sensor_word = deg_to_raw(-10.125);
      chk("v6_model_word", 32'(sensor_word), 32'h0000FF5E);
      push_conv();
      pulse_start();
      wait_valid(6, 3000);
      wait_cycles(20);
      chk("v6_temp_raw", 32'(temp_raw), 32'h0000FF5E);
      chk("v6_valid_count", valid_cnt, 6);
      chk("v6_script_done", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ds18b20_sched.md
DS18B20_SCHED -- requirements
Module: ds18b20_sched

Interface
REQ-001 Parameter TIME_750ms, default 37_499_999, is the terminal count of the conversion wait in clk cycles (750 ms at 50 MHz); simulation overrides it.
REQ-002 Parameter AUTO_GAP, default 4_999_999, sets idle cycles between auto-mode conversions.
REQ-003 Port clk, input, 1: single system clock; every register updates on its rising edge.
REQ-004 Port rst_n, input, 1: reset; synchronous, active-low.
REQ-005 Port start, input, 1: single-cycle pulse that requests one conversion.
REQ-006 Port auto_en, input, 1: when high, conversions repeat continuously.
REQ-007 Port phy_req, output, 1: transaction request to the 1-wire byte PHY.
REQ-008 Port phy_cmd, output, 2: PHY operation; 0=RESET, 1=WRITE, 2=READ.
REQ-009 Port phy_wdata, output, 8: byte to transmit on a WRITE.
REQ-010 Port phy_done, input, 1: single-cycle completion pulse from the PHY.
REQ-011 Port phy_rdata, input, 8: received byte; valid while phy_done is high.
REQ-012 Port phy_presence, input, 1: presence pulse detected; valid with phy_done of a RESET.
REQ-013 Port temp_raw, output, 16: last raw temperature as {MSB,LSB}, two's complement, 1/16 °C per LSB.
REQ-014 Port temp_valid, output, 1: single-cycle pulse marking a new temp_raw.
REQ-015 Port busy, output, 1: high in every state except IDLE and GAP.
REQ-016 Port err_np, output, 1: sticky no-presence flag; cleared by the next accepted start.

Function
REQ-017 FSM states and order: IDLE -> RST1 -> SKIP1(0xCC) -> CONV(0x44) -> WAIT -> RST2 -> SKIP2(0xCC) -> RDCMD(0xBE) -> RDL -> RDH -> DONE.
- From DONE: go to GAP when auto_en=1, otherwise to IDLE.
REQ-018 Leave IDLE when start=1 or auto_en=1; when both are high in the same cycle, run a single conversion.
REQ-019 Ignore start while busy=1; do not queue it.
REQ-020 In each PHY state, assert phy_req with phy_cmd and phy_wdata stable; hold them until the phy_done cycle, drop phy_req on the next cycle, and enter the next state on that same cycle.
REQ-021 Ignore phy_done received while phy_req is low.
REQ-022 On phy_done of RST1 or RST2 with phy_presence=0, set err_np, go to IDLE, and do not pulse temp_valid.
REQ-023 WAIT: the counter runs from 0 to TIME_750ms inclusive (TIME_750ms+1 cycles), then goes to RST2; phy_req stays low throughout.
REQ-024 RDL captures phy_rdata into the LSB holding register; RDH captures the MSB.
REQ-025 DONE lasts one cycle; load temp_raw and pulse temp_valid there, exactly one cycle after RDH's phy_done.
REQ-026 GAP counts AUTO_GAP+1 cycles, then returns to RST1.
- If auto_en=0 during GAP, go to IDLE.
REQ-027 Clearing auto_en mid-conversion completes the current conversion, then goes to IDLE.

Reset
REQ-028 While rst_n=0 on a clock edge, set state=IDLE and counters=0.
- Outputs: phy_req=0, phy_cmd=0, phy_wdata=0, temp_raw=0, temp_valid=0, busy=0, err_np=0.
REQ-029 Reset asserted mid-transaction drops phy_req on that edge; ignore any later phy_done until a new request is issued.

Structure
REQ-030 Shared package ds18b20_pkg holds:
- ROM/function command bytes 0xCC, 0x44, 0xBE;
- phy_cmd encodings;
- the FSM state encoding.
REQ-031 A single sub-module, ds18b20_dly_cnt, implements the loadable terminal-count counter shared by WAIT and GAP; all else stays in ds18b20_sched.

Verification
REQ-032 Bench coverage (TIME_750ms=999, AUTO_GAP=99, PHY model at +30.8125 °C):
- V1: start pulse -> PHY sees RESET, W 0xCC, W 0x44, 1000-cycle gap, RESET, W 0xCC, W 0xBE, R, R; then temp_raw=0x01ED with one temp_valid pulse.
- V2: model returns presence=0 on RST1 -> err_np=1, busy=0, no temp_valid, no WRITE issued.
- V3: start re-pulsed during WAIT -> no extra transaction; exactly one temp_valid.
- V4: auto_en=1 for 3 conversions -> 3 temp_valid pulses at most 100 cycles apart plus conversion time; auto_en=0 during GAP -> IDLE.
- V5: rst_n=0 while phy_req=1 in RDL -> phy_req=0 next edge, temp_raw=0, a stale phy_done is ignored.
- V6: model at -10.125 °C -> temp_raw=0xFF5E.
